rr_bus_scheduler: RTL and testbench

RR_BUS_SCHEDULER -- requirements
Module: rr_bus_scheduler

---
 rtl/rr_bus_scheduler.sv | 125 ++++++++++++
 tb/tb_rr_bus_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rr_bus_scheduler.sv
// Round-robin bus scheduler for four requesters: one-hot registered grant,
// hold limit of MAX_HOLD cycles, and a mandatory one-cycle gap between owners.
module rr_bus_scheduler #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic       timeout_q, timeout_d;

    logic [2:0] pick;
    logic       owner_done;
    logic       owner_req;
    logic       at_limit;
    logic       rel_now;

    // Search order ptr+1, ptr+2, ptr+3, ptr; result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd3;
            hcnt_q     <= 8'd0;
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hcnt_q     <= hcnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pick       = rr_pick(req, ptr_q);
    assign owner_done = done[grant_id_q];
    assign owner_req  = req[grant_id_q];
    assign at_limit   = (hcnt_q == HOLD_LAST);
    assign rel_now    = owner_done || !owner_req || at_limit;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hcnt_d     = hcnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                hcnt_d = 8'd0;
                if (pick[2]) begin
                    state_d    = GRANT;
                    grant_d    = onehot(pick[1:0]);
                    grant_id_d = pick[1:0];
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                end
            end
            GRANT: begin
                if (rel_now) begin
                    state_d   = GAP;
                    grant_d   = 4'b0000;
                    ptr_d     = grant_id_q;
                    hcnt_d    = 8'd0;
                    // Flag a revoke only when the hold limit alone ended the tenure.
                    timeout_d = at_limit && !owner_done && owner_req;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                hcnt_d  = 8'd0;
            end
        endcase
    end

    always_comb begin
        grant    = grant_q;
        grant_id = grant_id_q;
        busy     = |grant_q;
        timeout  = timeout_q;
    end

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Directed bench for rr_bus_scheduler (MAX_HOLD = 8): rotation, early done,
// timeout, coincident release, mid-grant reset, foreign done and request drop.
module tb_rr_bus_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    int n_chk;
    int n_pass;

    rr_bus_scheduler #(.MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input string tag, input logic [3:0] g, input logic [1:0] id, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, ".grant"}, 8'(grant), 8'(g));
            chk({tag, ".busy"}, 8'(busy), 8'd1);
            chk({tag, ".id"}, 8'(grant_id), 8'(id));
            chk({tag, ".tmo"}, 8'(timeout), 8'd0);
        end
    endtask

    task automatic gap(input string tag, input logic to);
        tick();
        chk({tag, ".gap_grant"}, 8'(grant), 8'd0);
        chk({tag, ".gap_busy"}, 8'(busy), 8'd0);
        chk({tag, ".gap_tmo"}, 8'(timeout), 8'(to));
    endtask

    // Hold reset with all inputs active, confirm reset outputs, then release.
    task automatic do_reset(input string tag, input logic [3:0] r);
        rst  = 1'b0;
        req  = 4'b1111;
        done = 4'b1111;
        tick();
        tick();
        chk({tag, ".rst_grant"}, 8'(grant), 8'd0);
        chk({tag, ".rst_busy"}, 8'(busy), 8'd0);
        chk({tag, ".rst_id"}, 8'(grant_id), 8'd0);
        chk({tag, ".rst_tmo"}, 8'(timeout), 8'd0);
        rst  = 1'b1;
        req  = r;
        done = 4'b0000;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        req    = 4'b0000;
        done   = 4'b0000;

        // Full rotation with every requester asking and never finishing.
        do_reset("rot", 4'b1111);
        hold("rot0", 4'b0001, 2'd0, 8);
        gap("rot0", 1'b1);
        hold("rot1", 4'b0010, 2'd1, 8);
        gap("rot1", 1'b1);
        hold("rot2", 4'b0100, 2'd2, 8);
        gap("rot2", 1'b1);
        hold("rot3", 4'b1000, 2'd3, 8);
        gap("rot3", 1'b1);
        hold("rot4", 4'b0001, 2'd0, 1);

        // Early done on the third grant cycle; same requester wins after the gap.
        do_reset("early", 4'b0010);
        hold("early", 4'b0010, 2'd1, 3);
        done = 4'b0010;
        gap("early", 1'b0);
        done = 4'b0000;
        hold("early_re", 4'b0010, 2'd1, 2);

        // Hold limit with two requesters.
        do_reset("tmo", 4'b0101);
        hold("tmo0", 4'b0001, 2'd0, 8);
        gap("tmo0", 1'b1);
        hold("tmo2", 4'b0100, 2'd2, 8);
        gap("tmo2", 1'b1);
        hold("tmo_back", 4'b0001, 2'd0, 1);

        // done arrives on the very cycle the limit is reached.
        do_reset("coin", 4'b0001);
        hold("coin", 4'b0001, 2'd0, 8);
        done = 4'b0001;
        gap("coin", 1'b0);
        done = 4'b0000;
        hold("coin_re", 4'b0001, 2'd0, 1);

        // Reset in the middle of a grant: no gap, priority restarts at requester 0.
        do_reset("mid", 4'b0100);
        hold("mid", 4'b0100, 2'd2, 3);
        rst = 1'b0;
        req = 4'b1100;
        tick();
        chk("mid.rst_grant", 8'(grant), 8'd0);
        chk("mid.rst_busy", 8'(busy), 8'd0);
        chk("mid.rst_tmo", 8'(timeout), 8'd0);
        rst = 1'b1;
        hold("mid_after", 4'b0100, 2'd2, 1);

        // Foreign done bits and non-owner req changes are ignored; owner drop releases.
        do_reset("frn", 4'b1111);
        hold("frn", 4'b0001, 2'd0, 2);
        done = 4'b1110;
        req  = 4'b0111;
        hold("frn_done", 4'b0001, 2'd0, 1);
        done = 4'b0000;
        hold("frn_clr", 4'b0001, 2'd0, 1);
        req = 4'b1110;
        gap("frn_drop", 1'b0);
        hold("frn_next", 4'b0010, 2'd1, 1);
        req = 4'b0000;
        gap("frn_last", 1'b0);
        tick();
        chk("idle.grant", 8'(grant), 8'd0);
        chk("idle.busy", 8'(busy), 8'd0);
        chk("idle.tmo", 8'(timeout), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
